// File: rtl/decoder3to8_strobe.sv
// rtl/decoder3to8_strobe.sv - 3-to-8 one-hot strobe generator with handshake, pulse length and idle gap
module decoder3to8_strobe #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    output logic [7:0] y,
    output logic       busy,
    output logic       done
);

    localparam int MAX_PG = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int MAX_CT = (MAX_PG > 2) ? MAX_PG : 2;
    localparam int CW     = $clog2(MAX_CT);

    localparam logic [CW-1:0] PULSE_RELOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_RELOAD   = CW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    assign in_ready = en && (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            y     <= 8'd0;
            done  <= 1'b0;
            cnt   <= '0;
        end else if (!en) begin
            // Abort drops everything without a done pulse; no code is remembered.
            state <= IDLE;
            y     <= 8'd0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        y     <= 8'd1 << in_code;
                        cnt   <= PULSE_RELOAD;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        y    <= 8'd0;
                        done <= 1'b1;
                        if (GAP_LEN == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                            cnt   <= GAP_RELOAD;
                        end
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    y     <= 8'd0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder3to8_strobe.sv
// tb/tb_decoder3to8_strobe.sv - table-driven bench for decoder3to8_strobe
module tb_decoder3to8_strobe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, in_valid;
    logic [2:0] in_code;
    logic       in_ready, busy, done;
    logic [7:0] y;

    logic       enb, vb;
    logic [2:0] cb;
    logic       rdyb, busyb, doneb;
    logic [7:0] yb;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decoder3to8_strobe #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_code(in_code),
        .in_ready(in_ready), .y(y), .busy(busy), .done(done)
    );

    decoder3to8_strobe #(.PULSE_LEN(1), .GAP_LEN(0)) dut_b (
        .clk(clk), .rst(rst), .en(enb), .in_valid(vb), .in_code(cb),
        .in_ready(rdyb), .y(yb), .busy(busyb), .done(doneb)
    );

    typedef struct {
        logic       en;
        logic       vld;
        logic [2:0] code;
        logic [7:0] y;
        logic       busy;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic e, input logic v, input logic [2:0] c,
                                input logic [7:0] ey, input logic eb, input logic ed,
                                input logic er);
        vec_t r;
        r.en = e; r.vld = v; r.code = c; r.y = ey; r.busy = eb; r.done = ed; r.rdy = er;
        return r;
    endfunction

    function automatic int popcnt(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [2:0] enc8to3(input logic [7:0] v);
        logic [2:0] r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int        exp_code;
        int        cur_code;
        int        last_start;
        logic [7:0] prev_y;

        // en, vld, code, y, busy, done, rdy (inputs before edge, outputs after it)
        tbl.push_back(mk(1, 1, 3'd5, 8'h20, 1, 0, 0));
        repeat (3) tbl.push_back(mk(1, 0, 3'd0, 8'h20, 1, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3'd3, 8'h08, 1, 0, 0));
        repeat (3) tbl.push_back(mk(1, 1, 3'd6, 8'h08, 1, 0, 0));
        tbl.push_back(mk(1, 1, 3'd6, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 1, 3'd6, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3'd6, 8'h40, 1, 0, 0));
        repeat (3) tbl.push_back(mk(1, 0, 3'd0, 8'h40, 1, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3'd2, 8'h04, 1, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h04, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(1, 1, 3'd1, 8'h02, 1, 0, 0));
        repeat (3) tbl.push_back(mk(1, 0, 3'd0, 8'h02, 1, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 1, 1, 0));
        tbl.push_back(mk(1, 0, 3'd0, 8'h00, 0, 0, 1));

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_code = 3'd0;
        enb = 1'b0; vb = 1'b0; cb = 3'd0;
        #12;
        chk("reset_y", 32'(y), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_ready", 32'(in_ready), 0);
        rst = 1'b0;
        tick();
        en = 1'b1;
        #1;
        chk("ready_after_en", 32'(in_ready), 1);

        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; in_valid = tbl[i].vld; in_code = tbl[i].code;
            tick();
            chk($sformatf("row%0d_y", i), 32'(y), 32'(tbl[i].y));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("row%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
        end

        // Round trip through an 8-to-3 encoder model with in_valid held high.
        en = 1'b1; in_valid = 1'b1; in_code = 3'd0;
        exp_code = 0; cur_code = 0; last_start = -1; prev_y = 8'd0;
        for (int cyc = 0; cyc < 80 && exp_code < 8; cyc++) begin
            tick();
            chk("rt_onehot0", 32'(popcnt(y) <= 1), 1);
            if (y != 8'd0 && prev_y == 8'd0) begin
                if (last_start >= 0) chk("rt_spacing", 32'(cyc - last_start), 6);
                last_start = cyc;
                cur_code = exp_code;
                exp_code++;
                in_code = 3'(exp_code);
                if (exp_code == 8) in_valid = 1'b0;
            end
            if (y != 8'd0) chk("rt_encode", 32'(enc8to3(y)), 32'(cur_code));
            prev_y = y;
        end
        chk("rt_all_codes", 32'(exp_code), 8);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && busy; k++) tick();
        chk("rt_drained", 32'(busy), 0);

        // Asynchronous reset in the middle of a pulse.
        in_valid = 1'b1; in_code = 3'd3;
        tick();
        chk("ar_pulse_y", 32'(y), 32'h08);
        in_valid = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("ar_y", 32'(y), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_done", 32'(done), 0);
        #1 rst = 1'b0;
        in_valid = 1'b1; in_code = 3'd7;
        tick();
        chk("ar_accept_y", 32'(y), 32'h80);
        chk("ar_accept_busy", 32'(busy), 1);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && busy; k++) tick();
        en = 1'b0;

        // Minimum configuration: back-to-back pulses of one cycle, no gap.
        enb = 1'b1; vb = 1'b1; cb = 3'd1;
        tick();
        chk("min_y1", 32'(yb), 32'h02);
        chk("min_done1", 32'(doneb), 0);
        chk("min_ready1", 32'(rdyb), 0);
        cb = 3'd2;
        tick();
        chk("min_y2", 32'(yb), 0);
        chk("min_done2", 32'(doneb), 1);
        chk("min_ready2", 32'(rdyb), 1);
        tick();
        chk("min_y3", 32'(yb), 32'h04);
        chk("min_done3", 32'(doneb), 0);
        vb = 1'b0;
        tick();
        chk("min_y4", 32'(yb), 0);
        chk("min_done4", 32'(doneb), 1);
        tick();
        chk("min_done5", 32'(doneb), 0);
        chk("min_busy5", 32'(busyb), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
